io_input_reader: RTL and testbench
==================================

// Module: io_input_reader
// PURPOSE
// Read-side counterpart of the IO write decoder: returns load data to the CPU for the word address space.
// Addr 0-31 pass data-memory read data; 32 returns LED state; 33 returns debounced switches; 34 returns button level + sticky press flags.
// Synchronises and debounces asynchronous switch/button pins; button presses latch until read (read-to-clear).
// PARAMETERS
// DATA_W          32  CPU data width
// N_LED           8   LED register width (read-back)
// N_SW            8   number of switch inputs
// N_BTN           4   number of button inputs (N_BTN <= 16)
// DEBOUNCE_CYCLES 16  consecutive stable cycles required to accept a new level (>=1)
// PORTS
// clk        in   1       system clock
// reset      in   1       synchronous, active-high reset
// addr       in   6       CPU word address of current load
// r_enable   in   1       CPU load strobe (qualifies read-to-clear)
// mem_rdata  in   DATA_W  data-memory read data
// led_state  in   N_LED   current LED register value
// sw_in      in   N_SW    async switch pins
// btn_in     in   N_BTN   async button pins (1 = pressed)
// rdata      out  DATA_W  load data to CPU
// btn_event  out  1       OR of all pending press flags
// BEHAVIOUR
// - Reset: sync FFs, debounced levels, counters, pending flags -> 0; hence btn_event=0, rdata@33/34=0.
// - Sync: 2-FF synchroniser per pin; synced value lags pin by 2 edges.
// - Debounce per bit: counter cnt (width $clog2(DEBOUNCE_CYCLES+1)).
//   synced==stable -> cnt<=0. synced!=stable -> cnt<=cnt+1; when cnt+1==DEBOUNCE_CYCLES: stable<=synced, cnt<=0.
//   Pulse shorter than DEBOUNCE_CYCLES never changes stable; pin-to-stable latency = 2+DEBOUNCE_CYCLES edges.
// - Press latch: pending[i] set on edge where stable_btn[i] goes 0->1; release never sets.
//   Clear: r_enable=1 && addr==34 clears all pending at that clock edge.
//   Set and clear same edge -> set wins for that bit (press never lost); other bits clear.
// - Read mux (combinational, zero latency, from registered state):
//   addr<=31 -> mem_rdata; 32 -> zero-ext led_state; 33 -> zero-ext stable_sw;
//   34 -> bits[N_BTN-1:0]=stable_btn, bits[16+N_BTN-1:16]=pending, rest 0; 35-63 -> 0.
//   rdata on addr 34 shows pre-clear pending (clear takes effect after edge).
// - r_enable only affects clearing; rdata is driven regardless of r_enable.
// - btn_event = |pending, registered-state derived, no extra latency.
// - Reset mid-debounce discards partial count; pin still different after reset re-debounces from 0.
// STRUCTURE
// - Package io_pkg: IO_LED_ADDR=6'd32, IO_SW_ADDR=6'd33, IO_BTN_ADDR=6'd34, MEM_TOP_ADDR=6'd31, BTN_PEND_LSB=16;
//   shared with the write-side decoder.
// - Sub-module io_debounce (1 bit: 2-FF sync + counter + stable reg, param DEBOUNCE_CYCLES, output stable);
//   instantiated N_SW+N_BTN times via generate. Edge detect, pending latch, read mux stay in top.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
// 1 Reset: assert reset 2 cycles with pins active -> btn_event=0, rdata@33=0, rdata@34=0 on first cycle after release.
// 2 Switch debounce: sw_in=8'hA5 at edge 0 -> rdata@33=0 through edge 5, =32'h000000A5 after edge 6.
// 3 Glitch: sw_in[0]=1 for 3 cycles then 0 -> rdata@33 stays 0 for 20 cycles.
// 4 Press/read-clear: btn_in[1]=1 for 10 cycles then 0 -> while held rdata@34=32'h00020002, btn_event=1;
//   after release settle 32'h00020000; one read (r_enable=1, addr=34) -> next cycle 32'h0, btn_event=0.
// 5 Collision: btn[0] pending, btn[2] stable rises on same edge as clearing read -> after edge pending=4'b0100.
// 6 Mux: addr=5 mem_rdata=32'hDEADBEEF -> rdata=32'hDEADBEEF; addr=32 led_state=8'h3C -> 32'h3C; addr=40 -> 0.

Source files
------------

// File: rtl/io_pkg.sv
// ----------------------------------------------------------------------------
// io_pkg
// Shared IO address map for the CPU word address space. The read-side
// reader and the write-side decoder both import this package, so the two
// agree on where memory ends and where the peripheral registers sit.
//   - address constants for memory top, LEDs, switches and buttons
//   - bit position of the pending-press field in the button word
//   - readSel_e / decodeAddr: classifies a word address into a read source
// ----------------------------------------------------------------------------
package io_pkg;

   localparam logic [5:0] MEM_TOP_ADDR = 6'd31;
   localparam logic [5:0] IO_LED_ADDR  = 6'd32;
   localparam logic [5:0] IO_SW_ADDR   = 6'd33;
   localparam logic [5:0] IO_BTN_ADDR  = 6'd34;
   localparam int         BTN_PEND_LSB = 16;

   typedef enum logic [2:0] {
      SEL_MEM,
      SEL_LED,
      SEL_SW,
      SEL_BTN,
      SEL_ZERO
   } readSel_e;

   // Everything at or below MEM_TOP_ADDR is data memory; the three IO
   // registers follow, and the rest of the 6-bit space reads as zero.
   function automatic readSel_e decodeAddr(input logic [5:0] a);
      readSel_e sel;
      if (a <= MEM_TOP_ADDR) begin
         sel = SEL_MEM;
      end else if (a == IO_LED_ADDR) begin
         sel = SEL_LED;
      end else if (a == IO_SW_ADDR) begin
         sel = SEL_SW;
      end else if (a == IO_BTN_ADDR) begin
         sel = SEL_BTN;
      end else begin
         sel = SEL_ZERO;
      end
      return sel;
   endfunction

endpackage

// File: rtl/io_debounce.sv
// ----------------------------------------------------------------------------
// io_debounce
// One-bit synchroniser and debouncer for an asynchronous pin. The pin passes
// through a 2-FF synchroniser; a new level is accepted only after the
// synchronised value has differed from the accepted level for
// DEBOUNCE_CYCLES consecutive clock edges.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   pin_i    in   asynchronous pin
//   stable_o out  debounced (accepted) level
//   rise_o   out  high in the cycle whose clock edge accepts a 0->1 change,
//                 so the parent can latch a press on that same edge
// ----------------------------------------------------------------------------
module io_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   output logic stable_o,
   output logic rise_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(DEBOUNCE_CYCLES);

   logic             syncMeta_q;
   logic             syncOut_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W:0]   countInc;

   // The counter only runs while the synchronised value disagrees with the
   // accepted level; any agreement restarts it, so short pulses are dropped.
   // The increment is one bit wider so the limit compare cannot wrap.
   always_comb begin
      countInc = {1'b0, count_q} + 1'b1;
      count_d  = count_q;
      stable_d = stable_q;
      if (syncOut_q == stable_q) begin
         count_d = '0;
      end else if (countInc == LIMIT) begin
         stable_d = syncOut_q;
         count_d  = '0;
      end else begin
         count_d = countInc[CNT_W-1:0];
      end
   end

   // Synchroniser chain, counter and accepted level all clear on reset, which
   // also throws away any partially counted change.
   always_ff @(posedge clk) begin
      if (reset) begin
         syncMeta_q <= 1'b0;
         syncOut_q  <= 1'b0;
         stable_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         syncMeta_q <= pin_i;
         syncOut_q  <= syncMeta_q;
         stable_q   <= stable_d;
         count_q    <= count_d;
      end
   end

   assign stable_o = stable_q;
   assign rise_o   = stable_d & ~stable_q & ~reset;

endmodule

// File: rtl/io_input_reader.sv
// ----------------------------------------------------------------------------
// io_input_reader
// Read side of the IO map: returns load data to the CPU. Word addresses
// 0-31 pass data-memory read data, 32 reads back the LED register, 33 the
// debounced switches, 34 the debounced buttons plus sticky press flags.
// Press flags stay set until a load from address 34 clears them.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   addr       in   CPU word address of the current load
//   r_enable   in   CPU load strobe, qualifies read-to-clear
//   mem_rdata  in   data-memory read data
//   led_state  in   current LED register value
//   sw_in      in   asynchronous switch pins
//   btn_in     in   asynchronous button pins (1 = pressed)
//   rdata      out  load data to the CPU (combinational)
//   btn_event  out  OR of all pending press flags
// ----------------------------------------------------------------------------
module io_input_reader
   import io_pkg::*;
#(
   parameter int DATA_W          = 32,
   parameter int N_LED           = 8,
   parameter int N_SW            = 8,
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        addr,
   input  logic              r_enable,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [N_LED-1:0]  led_state,
   input  logic [N_SW-1:0]   sw_in,
   input  logic [N_BTN-1:0]  btn_in,
   output logic [DATA_W-1:0] rdata,
   output logic              btn_event
);

   logic [N_SW-1:0]  stableSw;
   logic [N_SW-1:0]  swRise;
   logic [N_BTN-1:0] stableBtn;
   logic [N_BTN-1:0] btnRise;
   logic [N_BTN-1:0] pending_q;
   logic [N_BTN-1:0] pending_d;
   logic             clearRead;
   logic             unusedSwRise;

   // One debouncer per switch and per button pin.
   for (genvar g = 0; g < N_SW; g++) begin : genSw
      io_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) uSwDeb (
         .clk     (clk),
         .reset   (reset),
         .pin_i   (sw_in[g]),
         .stable_o(stableSw[g]),
         .rise_o  (swRise[g])
      );
   end

   for (genvar g = 0; g < N_BTN; g++) begin : genBtn
      io_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) uBtnDeb (
         .clk     (clk),
         .reset   (reset),
         .pin_i   (btn_in[g]),
         .stable_o(stableBtn[g]),
         .rise_o  (btnRise[g])
      );
   end

   // Switches have no edge-triggered behaviour; their rise strobes are unused.
   assign unusedSwRise = &swRise;

   // A clearing read wipes every flag, but a press accepted on that same edge
   // is OR'ed back in afterwards so it is never lost.
   always_comb begin
      clearRead = r_enable && (addr == IO_BTN_ADDR);
      pending_d = (clearRead ? '0 : pending_q) | btnRise;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Read mux works from registered state only, so a clearing read still
   // returns the flags as they were before its clock edge.
   always_comb begin
      rdata = '0;
      unique case (decodeAddr(addr))
         SEL_MEM: rdata = mem_rdata;
         SEL_LED: rdata[N_LED-1:0] = led_state;
         SEL_SW:  rdata[N_SW-1:0] = stableSw;
         SEL_BTN: begin
            rdata[N_BTN-1:0]               = stableBtn;
            rdata[BTN_PEND_LSB +: N_BTN]   = pending_q;
         end
         default: rdata = '0;
      endcase
   end

   assign btn_event = |pending_q;

endmodule

// File: tb/tb_io_input_reader.sv
// ----------------------------------------------------------------------------
// tb_io_input_reader
// Directed bench for io_input_reader with DEBOUNCE_CYCLES = 4. A behavioural
// model tracks the pin history per edge and accepts a new level whenever the
// last four synchronised samples all disagree with the accepted level; a
// negedge process compares every cycle against it, and directed steps pin
// hand-computed literals.
// ----------------------------------------------------------------------------
module tb_io_input_reader;

   localparam int DC   = 4;
   localparam int NSW  = 8;
   localparam int NBTN = 4;
   localparam int NPIN = NSW + NBTN;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  addr;
   logic        r_enable;
   logic [31:0] mem_rdata;
   logic [7:0]  led_state;
   logic [7:0]  sw_in;
   logic [3:0]  btn_in;
   logic [31:0] rdata;
   logic        btn_event;

   int testsRun  = 0;
   int failCount = 0;
   bit checkEn   = 1'b0;

   // Model state: accepted levels, pending flags and per-edge history.
   logic [NSW-1:0]  mSw;
   logic [NBTN-1:0] mBtn;
   logic [NBTN-1:0] mPend;
   logic [NPIN-1:0] pinHist[$];
   bit              rstHist[$];

   io_input_reader #(
      .DATA_W(32), .N_LED(8), .N_SW(NSW), .N_BTN(NBTN), .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .r_enable (r_enable),
      .mem_rdata(mem_rdata),
      .led_state(led_state),
      .sw_in    (sw_in),
      .btn_in   (btn_in),
      .rdata    (rdata),
      .btn_event(btn_event)
   );

   always #5 clk = ~clk;

   // Synchronised value seen by the debounce logic at edge m: the pin as
   // sampled two edges earlier, or zero if either of those edges was in reset.
   function automatic logic syncedAt(int m, int b);
      logic [NPIN-1:0] s;
      if (rstHist[m-1] || rstHist[m-2]) return 1'b0;
      s = pinHist[m-2];
      return s[b];
   endfunction

   function automatic logic [31:0] modelRdata(logic [5:0] a, logic [31:0] mem, logic [7:0] led);
      if (a <= 6'd31) return mem;
      else if (a == 6'd32) return {24'b0, led};
      else if (a == 6'd33) return {24'b0, mSw};
      else if (a == 6'd34) return {12'b0, mPend, 12'b0, mBtn};
      else return 32'h0;
   endfunction

   // Advance one clock edge and update the model from the inputs that the
   // DUT sampled on that edge.
   task automatic tick();
      logic [NPIN-1:0] pinsNow;
      logic [NPIN-1:0] newLvl;
      logic [NPIN-1:0] oldLvl;
      bit              rstNow;
      bit              clrNow;
      bit              allFlip;
      int              n;
      pinsNow = {btn_in, sw_in};
      rstNow  = reset;
      clrNow  = r_enable && (addr == 6'd34);
      @(posedge clk);
      pinHist.push_back(pinsNow);
      rstHist.push_back(rstNow);
      n = pinHist.size() - 1;
      if (rstNow) begin
         mSw   = '0;
         mBtn  = '0;
         mPend = '0;
      end else begin
         oldLvl = {mBtn, mSw};
         newLvl = oldLvl;
         for (int b = 0; b < NPIN; b++) begin
            allFlip = 1'b1;
            for (int k = 0; k < DC; k++) begin
               if (syncedAt(n - k, b) == oldLvl[b]) allFlip = 1'b0;
            end
            if (allFlip) newLvl[b] = ~oldLvl[b];
         end
         mSw   = newLvl[NSW-1:0];
         mBtn  = newLvl[NPIN-1:NSW];
         mPend = (clrNow ? '0 : mPend) | (newLvl[NPIN-1:NSW] & ~oldLvl[NPIN-1:NSW]);
      end
      #1;
   endtask

   task automatic applyStimulus(input logic rst, input logic [7:0] sw, input logic [3:0] btn,
                                input logic ren, input logic [5:0] a);
      reset    = rst;
      sw_in    = sw;
      btn_in   = btn;
      r_enable = ren;
      addr     = a;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] expR, input logic expEv);
      #1;
      testsRun++;
      if (rdata !== expR) begin
         failCount++;
         $display("[TB] FAIL %s rdata: got %h expected %h", name, rdata, expR);
      end
      testsRun++;
      if (btn_event !== expEv) begin
         failCount++;
         $display("[TB] FAIL %s btn_event: got %b expected %b", name, btn_event, expEv);
      end
   endtask

   // Cycle-by-cycle comparison against the model once reset has been seen.
   initial begin
      logic [31:0] expR;
      forever begin
         @(negedge clk);
         if (checkEn) begin
            expR = modelRdata(addr, mem_rdata, led_state);
            testsRun++;
            if (rdata !== expR) begin
               failCount++;
               $display("[TB] FAIL model_rdata addr=%0d: got %h expected %h", addr, rdata, expR);
            end
            testsRun++;
            if (btn_event !== (|mPend)) begin
               failCount++;
               $display("[TB] FAIL model_btn_event: got %b expected %b", btn_event, |mPend);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < DC + 3; i++) begin
         pinHist.push_back('0);
         rstHist.push_back(1'b1);
      end
      mSw = '0; mBtn = '0; mPend = '0;
      mem_rdata = 32'h0;
      led_state = 8'h0;

      // Reset held two edges with every pin active.
      applyStimulus(1'b1, 8'hFF, 4'hF, 1'b0, 6'd33);
      tick();
      checkEn = 1'b1;
      tick();
      applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 6'd33);
      checkOutput("reset_sw", 32'h0, 1'b0);
      addr = 6'd34;
      checkOutput("reset_btn", 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) tick();

      // Switch debounce: pins change just after edge 0.
      applyStimulus(1'b0, 8'hA5, 4'h0, 1'b0, 6'd33);
      for (int k = 1; k <= 5; k++) begin
         tick();
         checkOutput("sw_wait", 32'h0, 1'b0);
      end
      tick();
      checkOutput("sw_accept", 32'h000000A5, 1'b0);
      sw_in = 8'h00;
      for (int i = 0; i < 8; i++) tick();
      checkOutput("sw_release", 32'h0, 1'b0);

      // Three-cycle glitch must never be accepted.
      sw_in = 8'h01;
      for (int i = 0; i < 3; i++) tick();
      sw_in = 8'h00;
      for (int i = 0; i < 20; i++) begin
         tick();
         checkOutput("sw_glitch", 32'h0, 1'b0);
      end

      // Reset in the middle of a debounce restarts the count from scratch.
      sw_in = 8'hFF;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checkOutput("rst_mid_wait", 32'h0, 1'b0);
      end
      tick();
      checkOutput("rst_mid_accept", 32'h000000FF, 1'b0);
      sw_in = 8'h00;
      for (int i = 0; i < 8; i++) tick();

      // Press button 1 for ten cycles, then read-to-clear.
      applyStimulus(1'b0, 8'h00, 4'h2, 1'b0, 6'd34);
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k < 6) checkOutput("btn_wait", 32'h0, 1'b0);
         else       checkOutput("btn_held", 32'h00020002, 1'b1);
      end
      btn_in = 4'h0;
      for (int i = 0; i < 8; i++) tick();
      checkOutput("btn_released", 32'h00020000, 1'b1);
      r_enable = 1'b1;
      checkOutput("btn_preclear", 32'h00020000, 1'b1);
      tick();
      r_enable = 1'b0;
      checkOutput("btn_cleared", 32'h0, 1'b0);

      // Collision: button 2 accepted on the same edge as a clearing read.
      btn_in = 4'h1;
      for (int i = 0; i < 8; i++) tick();
      checkOutput("coll_btn0_held", 32'h00010001, 1'b1);
      btn_in = 4'h0;
      for (int i = 0; i < 8; i++) tick();
      checkOutput("coll_btn0_pend", 32'h00010000, 1'b1);
      btn_in = 4'h4;
      for (int k = 1; k <= 5; k++) tick();
      checkOutput("coll_before", 32'h00010000, 1'b1);
      r_enable = 1'b1;
      tick();
      r_enable = 1'b0;
      checkOutput("coll_after", 32'h00040004, 1'b1);
      btn_in = 4'h0;
      for (int i = 0; i < 8; i++) tick();
      checkOutput("coll_released", 32'h00040000, 1'b1);
      r_enable = 1'b1;
      tick();
      r_enable = 1'b0;
      checkOutput("coll_cleared", 32'h0, 1'b0);

      // Read mux across the address map.
      mem_rdata = 32'hDEADBEEF;
      led_state = 8'h3C;
      addr = 6'd5;
      checkOutput("mux_mem5", 32'hDEADBEEF, 1'b0);
      addr = 6'd31;
      checkOutput("mux_mem31", 32'hDEADBEEF, 1'b0);
      tick();
      addr = 6'd32;
      checkOutput("mux_led", 32'h0000003C, 1'b0);
      addr = 6'd40;
      checkOutput("mux_unmapped40", 32'h0, 1'b0);
      tick();
      addr = 6'd63;
      checkOutput("mux_unmapped63", 32'h0, 1'b0);
      r_enable = 1'b1;
      addr = 6'd0;
      mem_rdata = 32'h12345678;
      checkOutput("mux_mem0", 32'h12345678, 1'b0);
      tick();
      r_enable = 1'b0;
      tick();

      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
